// File: rtl/capture_dump_if.sv
// Capture/dump controller bus: stimulus, RAM port and byte-transmit handshake.
// master = stimulus/RAM side, slave = capture_dump_ctrl.
interface capture_dump_if #(
  parameter int NUM_CH = 5,
  parameter int DEPTH  = 384
);
  localparam int LOG2 = $clog2(DEPTH);
  localparam int CHW  = $clog2(NUM_CH);

  logic                  arm;
  logic                  wrt_smpl;
  logic                  trig;
  logic [LOG2-1:0]       trig_pos;
  logic [3:0]            decimator;
  logic                  dump;
  logic [CHW-1:0]        dump_ch;
  logic [NUM_CH*8-1:0]   rdata;
  logic                  we;
  logic [LOG2-1:0]       waddr;
  logic [LOG2-1:0]       raddr;
  logic [7:0]            resp;
  logic                  send_resp;
  logic                  resp_sent;
  logic                  armed;
  logic                  capture_done;
  logic                  dump_done;

  modport master (
    output arm, wrt_smpl, trig, trig_pos, decimator,
    output dump, dump_ch, rdata, resp_sent,
    input  we, waddr, raddr, resp, send_resp,
    input  armed, capture_done, dump_done
  );

  modport slave (
    input  arm, wrt_smpl, trig, trig_pos, decimator,
    input  dump, dump_ch, rdata, resp_sent,
    output we, waddr, raddr, resp, send_resp,
    output armed, capture_done, dump_done
  );
endinterface

// File: rtl/capture_dump_ctrl.sv
// Circular-buffer capture with pre/post trigger and byte-serial channel dump.
// Optional strobe decimation when CAP_DECIMATE_EN is defined.
module capture_dump_ctrl #(
  parameter int NUM_CH = 5,
  parameter int DEPTH  = 384
) (
  input logic           clk,
  input logic           rst,
  capture_dump_if.slave bus
);
  localparam int LOG2 = $clog2(DEPTH);
  localparam int CHW  = $clog2(NUM_CH);
  localparam int FW   = LOG2 + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_POST,
    S_DONE,
    S_DUMP_RD,
    S_DUMP_WT,
    S_DUMP_TX
  } state_t;

  state_t          r_state;
  logic [LOG2-1:0] r_waddr;
  logic [LOG2-1:0] r_raddr;
  logic [LOG2-1:0] r_post;
  logic [FW-1:0]   r_fill;
  logic [FW-1:0]   r_bcnt;
  logic [CHW-1:0]  r_ch;
  logic [7:0]      r_resp;
  logic            r_send;
  logic            r_armed;
  logic            r_cdone;
  logic            r_ddone;

  logic            w_cap;
  logic            w_dumping;
  logic            w_arm;
  logic            w_keep;
  logic            w_we;
  logic            w_trig_ok;
  logic            w_dump_ok;
  logic [FW-1:0]   w_fill_nxt;
  logic [FW-1:0]   w_thresh;
  logic [LOG2-1:0] w_waddr_inc;
  logic [LOG2-1:0] w_raddr_inc;
  logic [7:0]      w_byte;

  assign w_cap = (r_state == S_ARMED)
              || (r_state == S_POST);

  assign w_dumping = (r_state == S_DUMP_RD)
                  || (r_state == S_DUMP_WT)
                  || (r_state == S_DUMP_TX);

  assign w_arm = bus.arm && !w_dumping;

`ifdef CAP_DECIMATE_EN
  logic [15:0] r_dcnt;
  logic [15:0] w_dmax;

  assign w_dmax = 16'((17'd1 << bus.decimator) - 17'd1);
  assign w_keep = bus.wrt_smpl && (r_dcnt == w_dmax);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_dcnt <= '0;
    end else if (w_arm) begin
      r_dcnt <= '0;
    end else if (w_cap && bus.wrt_smpl) begin
      r_dcnt <= w_keep ? '0 : r_dcnt + 16'd1;
    end
  end
`else
  logic w_unused_dec;

  assign w_unused_dec = ^bus.decimator;
  assign w_keep       = bus.wrt_smpl;
`endif

  assign w_we = w_cap && w_keep && !w_arm;

  // Fill count includes a sample written on the trigger cycle itself.
  assign w_fill_nxt = (w_keep && (r_fill != FW'(DEPTH)))
                    ? r_fill + FW'(1)
                    : r_fill;

  assign w_thresh  = FW'(DEPTH) - {1'b0, bus.trig_pos};
  assign w_trig_ok = bus.trig && (w_fill_nxt >= w_thresh);
  assign w_dump_ok = bus.dump && (int'(bus.dump_ch) < NUM_CH);

  assign w_waddr_inc = (r_waddr == LOG2'(DEPTH - 1))
                     ? '0
                     : r_waddr + LOG2'(1);

  assign w_raddr_inc = (r_raddr == LOG2'(DEPTH - 1))
                     ? '0
                     : r_raddr + LOG2'(1);

  always_comb begin
    w_byte = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (int'(r_ch) == k) begin
        w_byte = bus.rdata[k*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_waddr <= '0;
      r_raddr <= '0;
      r_post  <= '0;
      r_fill  <= '0;
      r_bcnt  <= '0;
      r_ch    <= '0;
      r_resp  <= '0;
      r_send  <= 1'b0;
      r_armed <= 1'b0;
      r_cdone <= 1'b0;
      r_ddone <= 1'b0;
    end else begin
      r_send  <= 1'b0;
      r_ddone <= 1'b0;
      if (w_we) begin
        r_waddr <= w_waddr_inc;
      end
      if (w_arm) begin
        r_state <= S_ARMED;
        r_waddr <= '0;
        r_fill  <= '0;
        r_post  <= '0;
        r_armed <= 1'b1;
        r_cdone <= 1'b0;
      end else begin
        unique case (r_state)
          S_IDLE: begin
          end
          S_ARMED: begin
            r_fill <= w_fill_nxt;
            if (w_trig_ok) begin
              if (bus.trig_pos == '0) begin
                r_state <= S_DONE;
                r_armed <= 1'b0;
                r_cdone <= 1'b1;
              end else begin
                r_state <= S_POST;
                r_post  <= bus.trig_pos;
              end
            end
          end
          S_POST: begin
            if (w_keep) begin
              r_post <= r_post - LOG2'(1);
              if (r_post == LOG2'(1)) begin
                r_state <= S_DONE;
                r_armed <= 1'b0;
                r_cdone <= 1'b1;
              end
            end
          end
          S_DONE: begin
            // waddr now points at the oldest sample
            if (w_dump_ok) begin
              r_state <= S_DUMP_RD;
              r_ch    <= bus.dump_ch;
              r_raddr <= r_waddr;
              r_bcnt  <= FW'(DEPTH);
            end
          end
          S_DUMP_RD: begin
            r_state <= S_DUMP_WT;
          end
          S_DUMP_WT: begin
            r_resp  <= w_byte;
            r_send  <= 1'b1;
            r_state <= S_DUMP_TX;
          end
          S_DUMP_TX: begin
            if (bus.resp_sent) begin
              r_bcnt  <= r_bcnt - FW'(1);
              r_raddr <= w_raddr_inc;
              if (r_bcnt == FW'(1)) begin
                r_state <= S_DONE;
                r_ddone <= 1'b1;
              end else begin
                r_state <= S_DUMP_RD;
              end
            end
          end
          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign bus.we           = w_we;
  assign bus.waddr        = r_waddr;
  assign bus.raddr        = r_raddr;
  assign bus.resp         = r_resp;
  assign bus.send_resp    = r_send;
  assign bus.armed        = r_armed;
  assign bus.capture_done = r_cdone;
  assign bus.dump_done    = r_ddone;
endmodule

// File: tb/tb_capture_dump_ctrl.sv
// Randomized bench for capture_dump_ctrl against a queue-based capture model.
// Decimation scenario runs only when CAP_DECIMATE_EN is defined.
module tb_capture_dump_ctrl;
  localparam int NUM_CH = 5;
  localparam int DEPTH  = 16;
  localparam int LOG2   = $clog2(DEPTH);
  localparam int CHW    = $clog2(NUM_CH);
  localparam int M_IDLE = 0;
  localparam int M_ARM  = 1;
  localparam int M_POST = 2;
  localparam int M_DONE = 3;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  capture_dump_if #(.NUM_CH(NUM_CH), .DEPTH(DEPTH)) bus ();

  capture_dump_ctrl #(.NUM_CH(NUM_CH), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [NUM_CH*8-1:0] mem [DEPTH];
  logic [NUM_CH*8-1:0] wdata;

  always @(posedge clk) begin
    if (bus.we) mem[bus.waddr] <= wdata;
    bus.rdata <= mem[bus.raddr];
  end

  int n_we;
  int n_sr;
  int n_dd;

  initial begin
    n_we = 0;
    n_sr = 0;
    n_dd = 0;
  end

  always @(negedge clk) begin
    if (bus.we) n_we++;
    if (bus.send_resp) n_sr++;
    if (bus.dump_done) n_dd++;
  end

  int n_chk;
  int n_err;

  // Reference model: phase, writes since arm, strobes since arm, last DEPTH samples.
  int ph;
  int m_wr;
  int m_scnt;
  int m_post;
  int tp;
  int dec;
  logic [NUM_CH*8-1:0] q [$];

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit m_keep();
`ifdef CAP_DECIMATE_EN
    int p;
    p = 1 << dec;
    return (m_scnt % p) == (p - 1);
`else
    return 1'b1;
`endif
  endfunction

  task automatic model_clear(int new_ph);
    ph     = new_ph;
    m_wr   = 0;
    m_scnt = 0;
    m_post = 0;
    q.delete();
  endtask

  task automatic cap_cyc(bit s, bit t);
    bit keep;
    bus.wrt_smpl = s;
    bus.trig     = t;
    for (int k = 0; k < NUM_CH; k++) wdata[k*8 +: 8] = 8'($urandom);
    wdata[2*8 +: 8] = 8'(m_wr % DEPTH);
    @(negedge clk);
    keep = 1'b0;
    if (ph == M_ARM || ph == M_POST) keep = s && m_keep();
    check("we", 32'(bus.we), 32'(keep));
    check("waddr", 32'(bus.waddr), 32'(m_wr % DEPTH));
    check("armed", 32'(bus.armed), 32'(ph == M_ARM || ph == M_POST));
    check("capture_done", 32'(bus.capture_done), 32'(ph == M_DONE));
    if (ph == M_ARM || ph == M_POST) begin
      if (s) m_scnt++;
      if (keep) begin
        q.push_back(wdata);
        if (q.size() > DEPTH) void'(q.pop_front());
        m_wr++;
      end
      if (ph == M_ARM) begin
        if (t && q.size() >= DEPTH - tp) begin
          if (tp == 0) ph = M_DONE;
          else begin
            ph     = M_POST;
            m_post = tp;
          end
        end
      end else if (keep) begin
        m_post--;
        if (m_post == 0) ph = M_DONE;
      end
    end
    @(posedge clk);
    #1;
    bus.wrt_smpl = 1'b0;
    bus.trig     = 1'b0;
  endtask

  task automatic do_arm(int tpv, int decv, bit with_dump);
    bus.trig_pos  = LOG2'(tpv);
    bus.decimator = 4'(decv);
    bus.arm       = 1'b1;
    bus.dump      = with_dump;
    bus.dump_ch   = '0;
    @(negedge clk);
    check("we_on_arm", 32'(bus.we), 0);
    @(posedge clk);
    #1;
    bus.arm  = 1'b0;
    bus.dump = 1'b0;
    model_clear(M_ARM);
    tp  = tpv;
    dec = decv;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    model_clear(M_IDLE);
  endtask

  task automatic check_reset_state(string tag);
    @(negedge clk);
    check({tag, "_armed"}, 32'(bus.armed), 0);
    check({tag, "_capture_done"}, 32'(bus.capture_done), 0);
    check({tag, "_send_resp"}, 32'(bus.send_resp), 0);
    check({tag, "_dump_done"}, 32'(bus.dump_done), 0);
    check({tag, "_we"}, 32'(bus.we), 0);
    check({tag, "_waddr"}, 32'(bus.waddr), 0);
    check({tag, "_raddr"}, 32'(bus.raddr), 0);
    check({tag, "_resp"}, 32'(bus.resp), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic ignored_dump(int ch);
    int sr0;
    sr0         = n_sr;
    bus.dump    = 1'b1;
    bus.dump_ch = CHW'(ch);
    cap_cyc(1'b0, 1'b0);
    bus.dump = 1'b0;
    repeat (5) cap_cyc(1'b0, 1'b0);
    check("ignored_dump_send_resp", 32'(n_sr - sr0), 0);
  endtask

  task automatic do_dump(int ch, int dly, int abort_at);
    int sr0;
    int dd0;
    int w;
    bit got;
    logic [NUM_CH*8-1:0] e;
    logic [7:0] exp_b;
    sr0         = n_sr;
    dd0         = n_dd;
    bus.dump    = 1'b1;
    bus.dump_ch = CHW'(ch);
    @(posedge clk);
    #1;
    bus.dump = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      w   = 0;
      got = 1'b0;
      while (!got && w < 20) begin
        @(negedge clk);
        if (bus.send_resp) got = 1'b1;
        else begin
          w++;
          @(posedge clk);
          #1;
        end
      end
      check("send_resp_timeout", 32'(got), 1);
      if (!got) return;
      e     = q[i];
      exp_b = e[ch*8 +: 8];
      check("resp_byte", 32'(bus.resp), 32'(exp_b));
      check("capture_done_in_dump", 32'(bus.capture_done), 1);
      if (i == abort_at) begin
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_clear(M_IDLE);
        check_reset_state("abort");
        sr0 = n_sr;
        repeat (10) cap_cyc(1'b1, 1'b0);
        check("abort_no_send_resp", 32'(n_sr - sr0), 0);
        return;
      end
      for (int d = 1; d <= dly; d++) begin
        @(posedge clk);
        #1;
        if (d == dly) bus.resp_sent = 1'b1;
        @(negedge clk);
        check("resp_hold", 32'(bus.resp), 32'(exp_b));
        check("send_resp_pulse", 32'(bus.send_resp), 0);
      end
      @(posedge clk);
      #1;
      bus.resp_sent = 1'b0;
    end
    @(negedge clk);
    check("dump_done_pulse", 32'(bus.dump_done), 1);
    @(posedge clk);
    #1;
    bus.resp_sent = 1'b1;
    cap_cyc(1'b1, 1'b0);
    bus.resp_sent = 1'b0;
    cap_cyc(1'b0, 1'b0);
    check("dump_done_count", 32'(n_dd - dd0), 1);
    check("dump_byte_count", 32'(n_sr - sr0), DEPTH);
  endtask

  initial begin
    int we0;
    int sr0;
    int cyc;
    int ch;
    n_chk         = 0;
    n_err         = 0;
    rst           = 1'b1;
    bus.arm       = 1'b0;
    bus.wrt_smpl  = 1'b0;
    bus.trig      = 1'b0;
    bus.trig_pos  = '0;
    bus.decimator = '0;
    bus.dump      = 1'b0;
    bus.dump_ch   = '0;
    bus.resp_sent = 1'b0;
    wdata         = '0;
    tp            = 0;
    dec           = 0;
    model_clear(M_IDLE);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check_reset_state("reset");
    ignored_dump(1);

    // Pre-trigger fill, trigger on strobe 12, four post samples.
    we0 = n_we;
    do_arm(4, 0, 1'b0);
    for (int i = 1; i <= 20; i++) cap_cyc(1'b1, i == 12);
    check("pretrig_we_total", 32'(n_we - we0), 16);
    do_dump(2, 3, -1);
    for (int c = NUM_CH; c < (1 << CHW); c++) ignored_dump(c);

    // Early trigger ignored, later one accepted.
    we0 = n_we;
    do_arm(8, 0, 1'b0);
    repeat (3) cap_cyc(1'b1, 1'b0);
    cap_cyc(1'b0, 1'b1);
    check("early_trig_armed", 32'(bus.armed), 1);
    repeat (5) cap_cyc(1'b1, 1'b0);
    cap_cyc(1'b0, 1'b1);
    repeat (10) cap_cyc(1'b1, 1'b0);
    check("late_trig_we_total", 32'(n_we - we0), 16);
    do_dump(1, 2, 5);

    for (int it = 0; it < 30; it++) begin
`ifdef CAP_DECIMATE_EN
      do_arm($urandom_range(0, DEPTH - 1), $urandom_range(0, 2), 1'b0);
`else
      do_arm($urandom_range(0, DEPTH - 1), $urandom_range(0, 15), 1'b0);
`endif
      if ($urandom_range(0, 9) == 0) begin
        repeat ($urandom_range(1, 10)) cap_cyc(1'b1, 1'b0);
        do_arm(tp, dec, 1'b0);
      end
      cyc = 0;
      while (ph != M_DONE && cyc < 600) begin
        cap_cyc($urandom_range(0, 99) < 60, $urandom_range(0, 99) < 8);
        cyc++;
      end
      check("capture_timeout", 32'(ph == M_DONE), 1);
      if (ph != M_DONE) begin
        do_reset();
        continue;
      end
      repeat ($urandom_range(1, 4)) cap_cyc(1'b1, 1'b1);
      ch = $urandom_range(0, NUM_CH - 1);
      do_dump(ch, $urandom_range(1, 4), -1);
    end

    // Arm and dump together in DONE: arm wins.
    sr0 = n_sr;
    do_arm(2, 0, 1'b1);
    repeat (6) cap_cyc(1'b0, 1'b0);
    check("arm_vs_dump_send_resp", 32'(n_sr - sr0), 0);

`ifdef CAP_DECIMATE_EN
    we0 = n_we;
    do_arm(0, 2, 1'b0);
    for (int i = 1; i <= 64; i++) cap_cyc(1'b1, i == 64);
    check("decim_we_total", 32'(n_we - we0), 16);
    check("decim_done", 32'(ph == M_DONE), 1);
    cap_cyc(1'b0, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
